// File: rtl/seg_frame_integrator_if.sv
// Frame / result handshake bundle for seg_frame_integrator.
// master : producer side (drives start, min_count, frames, result_ready)
// slave  : integrator side (drives frame_ready, busy, frames_seen, result)
`ifndef BITMAP_NB_SEGMENTS
`define BITMAP_NB_SEGMENTS 7
`endif

interface seg_frame_integrator_if #(
  parameter int unsigned NB_SEGMENTS = `BITMAP_NB_SEGMENTS,
  parameter int unsigned WINDOW_LOG2 = 4,
  parameter int unsigned CNT_W       = WINDOW_LOG2 + 1
);
  logic                   start;
  logic [CNT_W-1:0]       min_count;
  logic                   frame_valid;
  logic                   frame_ready;
  logic [NB_SEGMENTS-1:0] frame_bits;
  logic                   busy;
  logic [WINDOW_LOG2-1:0] frames_seen;
  logic                   result_valid;
  logic                   result_ready;
  logic [NB_SEGMENTS-1:0] result_bitmap;

  modport master (
    output start, min_count, frame_valid, frame_bits, result_ready,
    input  frame_ready, busy, frames_seen, result_valid, result_bitmap
  );

  modport slave (
    input  start, min_count, frame_valid, frame_bits, result_ready,
    output frame_ready, busy, frames_seen, result_valid, result_bitmap
  );
endinterface

// File: rtl/seg_frame_integrator.sv
// seg_frame_integrator: counts, per segment, how many frames of a 2^WINDOW_LOG2 window
// had that segment lit, then reports which segments reached the latched min_count.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   abort - (only with SEG_FRAME_INTEGRATOR_ABORT_EN) drops the window in progress
//   bus   - seg_frame_integrator_if.slave: start/min_count, frame handshake,
//           busy/frames_seen status, result handshake
// Optional feature macro: SEG_FRAME_INTEGRATOR_ABORT_EN (adds the abort input).
`ifndef BITMAP_NB_SEGMENTS
`define BITMAP_NB_SEGMENTS 7
`endif

module seg_frame_integrator #(
  parameter int unsigned NB_SEGMENTS = `BITMAP_NB_SEGMENTS,
  parameter int unsigned WINDOW_LOG2 = 4,
  parameter int unsigned CNT_W       = WINDOW_LOG2 + 1
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef SEG_FRAME_INTEGRATOR_ABORT_EN
  input  logic                        abort,
`endif
  seg_frame_integrator_if.slave       bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StReport} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q [NB_SEGMENTS];
  logic [CNT_W-1:0]       cnt_d [NB_SEGMENTS];
  logic [WINDOW_LOG2-1:0] frames_q, frames_d;
  logic [CNT_W-1:0]       min_q, min_d;
  logic [NB_SEGMENTS-1:0] bitmap_q, bitmap_d;
  logic                   abort_req;

`ifdef SEG_FRAME_INTEGRATOR_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    min_d    = min_q;
    bitmap_d = bitmap_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StAccum;
          cnt_d    = '{default: '0};
          frames_d = '0;
          min_d    = bus.min_count;
          bitmap_d = '0;
        end
      end
      StAccum: begin
        // frame_ready is constantly high here, so frame_valid alone means acceptance
        if (bus.frame_valid) begin
          for (int i = 0; i < NB_SEGMENTS; i++) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(bus.frame_bits[i]);
          end
          frames_d = frames_q + WINDOW_LOG2'(1);
          if (&frames_q) begin
            state_d = StReport;
            // Compare against the updated counts so the last frame is included
            for (int i = 0; i < NB_SEGMENTS; i++) begin
              bitmap_d[i] = (cnt_d[i] >= min_q);
            end
          end
        end
      end
      StReport: begin
        if (bus.result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over frame acceptance and result_ready
    if (abort_req && (state_q != StIdle)) begin
      state_d  = StIdle;
      cnt_d    = '{default: '0};
      frames_d = '0;
      bitmap_d = bitmap_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '{default: '0};
      frames_q <= '0;
      min_q    <= '0;
      bitmap_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      min_q    <= min_d;
      bitmap_q <= bitmap_d;
    end
  end

  assign bus.frame_ready   = (state_q == StAccum);
  assign bus.busy          = (state_q != StIdle);
  assign bus.result_valid  = (state_q == StReport);
  assign bus.frames_seen   = frames_q;
  assign bus.result_bitmap = bitmap_q;

endmodule

// File: tb/tb_seg_frame_integrator.sv
// Directed bench for seg_frame_integrator (16-frame window, 7 segments).
module tb_seg_frame_integrator;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef SEG_FRAME_INTEGRATOR_ABORT_EN
  logic abort = 1'b0;
`endif
  int total = 0;
  int bad   = 0;

  seg_frame_integrator_if #(.NB_SEGMENTS(7), .WINDOW_LOG2(4), .CNT_W(5)) bus ();

  seg_frame_integrator #(.NB_SEGMENTS(7), .WINDOW_LOG2(4), .CNT_W(5)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef SEG_FRAME_INTEGRATOR_ABORT_EN
    .abort(abort),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] m);
    bus.start     = 1'b1;
    bus.min_count = m;
    step();
    bus.start     = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] b, input int gap);
    bus.frame_valid = 1'b0;
    repeat (gap) step();
    bus.frame_valid = 1'b1;
    bus.frame_bits  = b;
    step();
    bus.frame_valid = 1'b0;
    bus.frame_bits  = '0;
  endtask

  task automatic finish_report();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.frame_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.frame_ready); end
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b exp=0", bus.result_valid); end
    total++; if (bus.result_bitmap !== 7'h00) begin bad++; $display("FAIL rst_bitmap got=%h exp=00", bus.result_bitmap); end
    step(); step();
    rst = 1'b0;
    step();
    do_start(5'd1);
    total++; if (bus.busy !== 1'b1 || bus.frame_ready !== 1'b1) begin
      bad++; $display("FAIL start_latency got busy=%b ready=%b exp 1/1", bus.busy, bus.frame_ready);
    end
    for (int i = 0; i < 5; i++) send_frame(7'h7F, 0);
    total++; if (bus.frames_seen !== 4'd5) begin bad++; $display("FAIL mid_frames got=%0d exp=5", bus.frames_seen); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.frame_ready !== 1'b0 || bus.frames_seen !== 4'd0 ||
                 bus.result_valid !== 1'b0 || bus.result_bitmap !== 7'h00) begin
      bad++; $display("FAIL async_rst got busy=%b ready=%b fs=%0d rv=%b bm=%h exp all 0",
                      bus.busy, bus.frame_ready, bus.frames_seen, bus.result_valid, bus.result_bitmap);
    end
    step();
    rst = 1'b0;
    step();
    do_start(5'd1);
    for (int i = 0; i < 16; i++) send_frame(7'h00, 0);
    total++; if (bus.result_valid !== 1'b1 || bus.result_bitmap !== 7'h00) begin
      bad++; $display("FAIL post_rst_window got rv=%b bm=%h exp 1/00", bus.result_valid, bus.result_bitmap);
    end
    finish_report();
  endtask

  task automatic test_full_visibility();
    do_start(5'd16);
    for (int i = 0; i < 15; i++) send_frame(7'h7F, 0);
    total++; if (bus.result_valid !== 1'b0 || bus.frames_seen !== 4'd15) begin
      bad++; $display("FAIL fv_pre got rv=%b fs=%0d exp 0/15", bus.result_valid, bus.frames_seen);
    end
    send_frame(7'h7F, 0);
    total++; if (bus.result_valid !== 1'b1 || bus.result_bitmap !== 7'h7F) begin
      bad++; $display("FAIL fv_result got rv=%b bm=%h exp 1/7f", bus.result_valid, bus.result_bitmap);
    end
    total++; if (bus.frames_seen !== 4'd0 || bus.frame_ready !== 1'b0) begin
      bad++; $display("FAIL fv_wrap got fs=%0d ready=%b exp 0/0", bus.frames_seen, bus.frame_ready);
    end
    // start while still in REPORT must not open a new window
    bus.start = 1'b1;
    finish_report();
    bus.start = 1'b0;
    total++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL fv_release got rv=%b busy=%b exp 0/0", bus.result_valid, bus.busy);
    end
  endtask

  task automatic test_threshold();
    do_start(5'd8);
    for (int i = 0; i < 16; i++) send_frame((i < 8) ? 7'h01 : 7'h00, 0);
    total++; if (bus.result_bitmap !== 7'h01) begin bad++; $display("FAIL thr8 got=%h exp=01", bus.result_bitmap); end
    finish_report();
    do_start(5'd9);
    for (int i = 0; i < 16; i++) send_frame((i < 8) ? 7'h01 : 7'h00, 0);
    total++; if (bus.result_bitmap !== 7'h00) begin bad++; $display("FAIL thr9 got=%h exp=00", bus.result_bitmap); end
    finish_report();
  endtask

  task automatic test_handshake();
    logic [6:0] fb;
    do_start(5'd8);
    // Changing min_count mid-window must not matter (0 would give 7f)
    bus.min_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      fb = 7'(i);
      if (i == 4) begin
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
      end
      send_frame(fb, int'($urandom_range(0, 3)));
      total++; if (bus.frames_seen !== 4'(i + 1)) begin
        bad++; $display("FAIL hs_count[%0d] got=%0d exp=%0d", i, bus.frames_seen, (i + 1) % 16);
      end
    end
    for (int c = 0; c < 5; c++) begin
      bus.start = 1'b1;
      total++; if (bus.result_valid !== 1'b1 || bus.busy !== 1'b1 || bus.result_bitmap !== 7'h0F) begin
        bad++; $display("FAIL hs_hold[%0d] got rv=%b busy=%b bm=%h exp 1/1/0f",
                        c, bus.result_valid, bus.busy, bus.result_bitmap);
      end
      step();
    end
    bus.start = 1'b0;
    finish_report();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hs_idle got busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_extremes();
    do_start(5'd0);
    for (int i = 0; i < 16; i++) send_frame(7'h00, 0);
    total++; if (bus.result_bitmap !== 7'h7F) begin bad++; $display("FAIL min0 got=%h exp=7f", bus.result_bitmap); end
    finish_report();
    do_start(5'd17);
    for (int i = 0; i < 16; i++) send_frame(7'h7F, 0);
    total++; if (bus.result_valid !== 1'b1 || bus.result_bitmap !== 7'h00) begin
      bad++; $display("FAIL min17 got rv=%b bm=%h exp 1/00", bus.result_valid, bus.result_bitmap);
    end
    finish_report();
  endtask

`ifdef SEG_FRAME_INTEGRATOR_ABORT_EN
  task automatic test_abort();
    do_start(5'd1);
    for (int i = 0; i < 3; i++) send_frame(7'h7F, 0);
    abort = 1'b1;
    bus.frame_valid = 1'b1;
    bus.frame_bits  = 7'h7F;
    step();
    abort = 1'b0;
    bus.frame_valid = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.frames_seen !== 4'd0) begin
      bad++; $display("FAIL abort_accum got busy=%b rv=%b fs=%0d exp 0/0/0",
                      bus.busy, bus.result_valid, bus.frames_seen);
    end
    step();
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL abort_noresult got=%b exp=0", bus.result_valid); end
    do_start(5'd1);
    for (int i = 0; i < 16; i++) send_frame(7'h00, 0);
    total++; if (bus.result_bitmap !== 7'h00) begin bad++; $display("FAIL abort_clear got=%h exp=00", bus.result_bitmap); end
    abort = 1'b1;
    bus.result_ready = 1'b1;
    step();
    abort = 1'b0;
    bus.result_ready = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      bad++; $display("FAIL abort_report got busy=%b rv=%b exp 0/0", bus.busy, bus.result_valid);
    end
  endtask
`endif

  initial begin
    bus.start        = 1'b0;
    bus.min_count    = '0;
    bus.frame_valid  = 1'b0;
    bus.frame_bits   = '0;
    bus.result_ready = 1'b0;
    test_reset();
    test_full_visibility();
    test_threshold();
    test_handshake();
    test_extremes();
`ifdef SEG_FRAME_INTEGRATOR_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
